mips_regfile_mp: RTL and testbench

Parametrised multi-port register file for the next-generation MIPS datapath. It replaces the fixed 32x32, 2-read/1-write file.
- Configurable width, depth, read-port count and write-port count.
- Write-first bypass.
- A sequential clear engine replaces the wide single-cycle reset fan-out, and can also be re-triggered at run time.
- A ready handshake tells the pipeline when the file is usable.
It sits between decode (reads) and writeback (writes), with a debug tap for the testbench result register.

---
 rtl/mips_rf_pkg.sv | 20 ++
 rtl/rf_clear_seq.sv | 76 +++++++
 rtl/mips_regfile_mp.sv | 167 ++++++++++++++++
 tb/tb_mips_regfile_mp.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_rf_pkg.sv
// mips_rf_pkg
//   Types and helpers shared by the parametrised MIPS register file.
//   - rf_state_t : operating state of the file (clearing / usable)
//   - rf_addr_w  : address width for a given register count
//   - RF_V0_IDX  : index of $v0, the register exposed on the debug tap
package mips_rf_pkg;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_t;

  localparam int RF_V0_IDX = 2;

  // At least one address bit, even for a two-entry file.
  function automatic int rf_addr_w(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/rf_clear_seq.sv
// rf_clear_seq
//   Sequential clear engine and ready generator for mips_regfile_mp.
//   After reset (or a run-time clear request) it walks the file one entry per
//   cycle writing zero, then raises ready. Clearing all DEPTH entries takes
//   exactly DEPTH rising edges.
// Ports:
//   clk       in   clock
//   reset     in   asynchronous, active-low reset
//   clear_req in   restart the clear walk from entry 0
//   clr_we    out  write-zero strobe for the array
//   clr_addr  out  entry being cleared this cycle
//   ready     out  file usable (READY state)
module rf_clear_seq
  import mips_rf_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = rf_addr_w(DEPTH)
)(
  input  logic          clk,
  input  logic          reset,
  input  logic          clear_req,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr,
  output logic          ready
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  rf_state_t     state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RF_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    case (state_q)
      RF_CLEAR: begin
        // The current entry is zeroed on every clearing edge; a repeated
        // request simply restarts the walk from entry 0.
        clr_we = 1'b1;
        if (clear_req) begin
          cnt_d = '0;
        end else if (cnt_q == LAST_IDX) begin
          state_d = RF_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      RF_READY: begin
        if (clear_req) begin
          state_d = RF_CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = RF_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  assign clr_addr = cnt_q;
  assign ready    = (state_q == RF_READY);

endmodule

// File: rtl/mips_regfile_mp.sv
// mips_regfile_mp
//   Parametrised multi-port register file: NUM_RD combinational read ports,
//   NUM_WR write ports (higher index wins on collisions), optional write-first
//   bypass, optional hardwired-zero register 0, sequential clear engine with a
//   ready handshake, and a debug tap on register DBG_IDX.
// Ports:
//   clk, reset        clock / asynchronous active-low reset
//   clear_req         re-zero the whole file (restarts the clear walk)
//   ready             file accepts reads/writes
//   we, wa, wd        per-port write enable / address / data (packed by port)
//   ra, rd            per-port read address / data (packed by port)
//   dbg_q             array value of register DBG_IDX, 0 when not ready
// Optional build macro MIPS_REGFILE_SCOREBOARD_EN adds a pending-producer
// scoreboard with ports mark_en, mark_addr (in) and rd_pending (out).
module mips_regfile_mp
  import mips_rf_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int DBG_IDX  = RF_V0_IDX,
  localparam int AW      = rf_addr_w(DEPTH)
)(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear_req,
  output logic                    ready,
  input  logic [NUM_WR-1:0]       we,
  input  logic [NUM_WR*AW-1:0]    wa,
  input  logic [NUM_WR*WIDTH-1:0] wd,
  input  logic [NUM_RD*AW-1:0]    ra,
  output logic [NUM_RD*WIDTH-1:0] rd,
  output logic [WIDTH-1:0]        dbg_q
`ifdef MIPS_REGFILE_SCOREBOARD_EN
  ,
  input  logic                    mark_en,
  input  logic [AW-1:0]           mark_addr,
  output logic [NUM_RD-1:0]       rd_pending
`endif
);

  localparam logic [AW-1:0] DBG_A = AW'(DBG_IDX);

  logic          clr_we;
  logic [AW-1:0] clr_addr;

  rf_clear_seq #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clear_seq (
    .clk       (clk),
    .reset     (reset),
    .clear_req (clear_req),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr),
    .ready     (ready)
  );

  // Unpacked views of the write ports plus the "write actually lands" flag.
  // A write lands only in READY, not alongside a clear request, and never to
  // a hardwired-zero register 0.
  logic [AW-1:0]    wa_a [NUM_WR];
  logic [WIDTH-1:0] wd_a [NUM_WR];
  logic [NUM_WR-1:0] wr_acc;

  for (genvar gi = 0; gi < NUM_WR; gi++) begin : g_wport
    assign wa_a[gi]   = wa[gi*AW +: AW];
    assign wd_a[gi]   = wd[gi*WIDTH +: WIDTH];
    assign wr_acc[gi] = ready && !clear_req && we[gi] &&
                        !((ZERO_REG != 0) && (wa_a[gi] == '0));
  end

  // Storage. No reset: contents are zeroed by the clear engine. Ports are
  // applied in ascending order so the highest-index port wins a collision.
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_addr] <= '0;
    end
    for (int k = 0; k < NUM_WR; k++) begin
      if (wr_acc[k]) begin
        mem_q[wa_a[k]] <= wd_a[k];
      end
    end
  end

`ifdef MIPS_REGFILE_SCOREBOARD_EN
  logic [DEPTH-1:0] pend_q, pend_d;
  logic             mark_ok;

  assign mark_ok = mark_en && !((ZERO_REG != 0) && (mark_addr == '0));

  always_comb begin
    pend_d = pend_q;
    if (!ready) begin
      pend_d = '0;
    end else begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (wr_acc[k]) begin
          pend_d[wa_a[k]] = 1'b0;
        end
      end
      // Applied after the write clears: a fresh producer outranks the write.
      if (mark_ok) begin
        pend_d[mark_addr] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end
`endif

  // Read ports.
  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rport
    logic [AW-1:0]    ra_j;
    logic             wr_hit;
    logic [WIDTH-1:0] byp_data;
    logic [WIDTH-1:0] rd_val;

    assign ra_j = ra[gi*AW +: AW];

    // Highest-index matching write port supplies the forwarded data.
    always_comb begin
      wr_hit   = 1'b0;
      byp_data = '0;
      for (int k = 0; k < NUM_WR; k++) begin
        if (wr_acc[k] && (wa_a[k] == ra_j)) begin
          wr_hit   = 1'b1;
          byp_data = wd_a[k];
        end
      end
    end

    always_comb begin
      rd_val = mem_q[ra_j];
      if ((BYPASS != 0) && wr_hit) begin
        rd_val = byp_data;
      end
      if (!ready || ((ZERO_REG != 0) && (ra_j == '0))) begin
        rd_val = '0;
      end
    end

    assign rd[gi*WIDTH +: WIDTH] = rd_val;

`ifdef MIPS_REGFILE_SCOREBOARD_EN
    // A write landing this cycle retires the producer unless a new one is
    // being marked for the same register in the same cycle.
    assign rd_pending[gi] = ready && pend_q[ra_j] &&
                            !((BYPASS != 0) && wr_hit &&
                              !(mark_en && (mark_addr == ra_j)));
`endif
  end

  assign dbg_q = ready ? mem_q[DBG_A] : '0;

endmodule

// File: tb/tb_mips_regfile_mp.sv
// tb_mips_regfile_mp
//   Self-checking bench. DUT A: 32x32, 2 read / 2 write, zero-reg, bypass.
//   DUT B: 8x32, 1 read / 1 write, no zero-reg, no bypass.
//   A behavioural model of DUT A (array + ready countdown) is checked every
//   cycle; a vector table and hand-written sequences cover the corner cases.
module tb_mips_regfile_mp;

  localparam int AW = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear_req;
  logic        ready;
  logic [1:0]  we;
  logic [9:0]  wa;
  logic [63:0] wd;
  logic [9:0]  ra;
  logic [63:0] rd;
  logic [31:0] dbg_q;
  logic        mark_en;
  logic [4:0]  mark_addr;
  logic [1:0]  rd_pending;

  logic        b_clear_req;
  logic        b_ready;
  logic [0:0]  b_we;
  logic [2:0]  b_wa;
  logic [31:0] b_wd;
  logic [2:0]  b_ra;
  logic [31:0] b_rd;
  logic [31:0] b_dbg;
  logic        b_mark_en;
  logic [2:0]  b_mark_addr;
  logic [0:0]  b_rd_pending;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mips_regfile_mp #(
    .WIDTH(32), .DEPTH(32), .NUM_RD(2), .NUM_WR(2),
    .ZERO_REG(1), .BYPASS(1), .DBG_IDX(2)
  ) u_dut (
    .clk(clk), .reset(reset), .clear_req(clear_req), .ready(ready),
    .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd), .dbg_q(dbg_q)
`ifdef MIPS_REGFILE_SCOREBOARD_EN
    , .mark_en(mark_en), .mark_addr(mark_addr), .rd_pending(rd_pending)
`endif
  );

  mips_regfile_mp #(
    .WIDTH(32), .DEPTH(8), .NUM_RD(1), .NUM_WR(1),
    .ZERO_REG(0), .BYPASS(0), .DBG_IDX(2)
  ) u_dut_b (
    .clk(clk), .reset(reset), .clear_req(b_clear_req), .ready(b_ready),
    .we(b_we), .wa(b_wa), .wd(b_wd), .ra(b_ra), .rd(b_rd), .dbg_q(b_dbg)
`ifdef MIPS_REGFILE_SCOREBOARD_EN
    , .mark_en(b_mark_en), .mark_addr(b_mark_addr), .rd_pending(b_rd_pending)
`endif
  );

  // ---------------- reference model of DUT A ----------------
  logic [31:0] m_mem [32];
  bit          m_ready;
  int          m_clear_left;   // edges still needed before the file is usable
  bit          m_pend [32];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit write_lands(input int k, input logic [4:0] a);
    return m_ready && !clear_req && we[k] && (wa[k*AW +: AW] == a) && (a != 0);
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (!m_ready || a == 0) return 32'h0;
    for (int k = 1; k >= 0; k--)
      if (write_lands(k, a)) return wd[k*32 +: 32];
    return m_mem[a];
  endfunction

  function automatic bit exp_pending(input logic [4:0] a);
    bit hit;
    if (!m_ready) return 1'b0;
    hit = write_lands(0, a) || write_lands(1, a);
    if (hit && !(mark_en && mark_addr == a)) return 1'b0;
    return m_pend[a];
  endfunction

  task automatic model_reset();
    m_ready      = 1'b0;
    m_clear_left = 32;
    foreach (m_pend[i]) m_pend[i] = 1'b0;
  endtask

  task automatic model_edge();
    if (!reset) return;
    if (!m_ready) begin
      m_mem[32 - m_clear_left] = 32'h0;
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      if (clear_req) m_clear_left = 32;
      else begin
        m_clear_left--;
        if (m_clear_left == 0) m_ready = 1'b1;
      end
    end else if (clear_req) begin
      m_ready      = 1'b0;
      m_clear_left = 32;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (we[k] && wa[k*AW +: AW] != 0) begin
          m_mem[wa[k*AW +: AW]]  = wd[k*32 +: 32];
          m_pend[wa[k*AW +: AW]] = 1'b0;
        end
      end
      if (mark_en && mark_addr != 0) m_pend[mark_addr] = 1'b1;
    end
  endtask

  task automatic model_check();
    check("ready", 64'(ready), 64'(m_ready));
    check("dbg_q", 64'(dbg_q), m_ready ? 64'(m_mem[2]) : 64'h0);
    for (int j = 0; j < 2; j++) begin
      check($sformatf("rd%0d(ra=%0d)", j, ra[j*AW +: AW]),
            64'(rd[j*32 +: 32]), 64'(exp_read(ra[j*AW +: AW])));
`ifdef MIPS_REGFILE_SCOREBOARD_EN
      check($sformatf("rd_pending%0d(ra=%0d)", j, ra[j*AW +: AW]),
            64'(rd_pending[j]), 64'(exp_pending(ra[j*AW +: AW])));
`endif
    end
  endtask

  task automatic settle();
    #2;
    model_check();
  endtask

  task automatic edge_();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic step();
    settle();
    edge_();
  endtask

  task automatic drive(input logic [1:0] w, input logic [4:0] a0, input logic [4:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input logic [4:0] r0, input logic [4:0] r1);
    we = w;
    wa = {a1, a0};
    wd = {d1, d0};
    ra = {r1, r0};
  endtask

  task automatic idle();
    drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0);
    clear_req = 1'b0;
    mark_en   = 1'b0;
    mark_addr = 5'd0;
  endtask

  // Assert reset between edges, hold it, release it at a falling edge.
  task automatic apply_reset(input string tag);
    reset = 1'b0;
    model_reset();
    #1;
    check({tag, "_ready_in_reset"}, 64'(ready), 64'h0);
    check({tag, "_dbg_in_reset"}, 64'(dbg_q), 64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Walk through a full clear: ready low for exactly 32 edges, then high.
  task automatic expect_clear_walk(input string tag, input bit poke_writes);
    for (int i = 0; i < 32; i++) begin
      if (poke_writes)
        drive(2'b11, 5'd5, 5'd6, $urandom, $urandom, 5'd5, 5'(i));
      settle();
      check($sformatf("%s_ready_low_%0d", tag, i), 64'(ready), 64'h0);
      check($sformatf("%s_dbg_zero_%0d", tag, i), 64'(dbg_q), 64'h0);
      edge_();
    end
    idle();
    ra = {5'd6, 5'd5};
    settle();
    check({tag, "_ready_high"}, 64'(ready), 64'h1);
    check({tag, "_rd5_zero"}, 64'(rd[31:0]), 64'h0);
    check({tag, "_rd6_zero"}, 64'(rd[63:32]), 64'h0);
    $display("%s: clear walk of 32 edges done, ready=%0b", tag, ready);
  endtask

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic [4:0]  ra0, ra1;
    logic [31:0] e_rd0, e_rd1, e_dbg;
  } vec_t;

  vec_t vt [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{2'b11, 5'd5, 5'd5, 32'h11, 32'h22, 5'd5, 5'd0, 32'h22, 32'h0, 32'h0};
    vt[1] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd3, 32'h22, 32'h0, 32'h0};
    vt[2] = '{2'b01, 5'd0, 5'd0, 32'hDEADBEEF, 32'h0, 5'd0, 5'd5, 32'h0, 32'h22, 32'h0};
    vt[3] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd2, 32'h0, 32'h0, 32'h0};
    vt[4] = '{2'b01, 5'd2, 5'd0, 32'h1234, 32'h0, 5'd2, 5'd7, 32'h1234, 32'h0, 32'h0};
    vt[5] = '{2'b10, 5'd3, 5'd9, 32'hFFFF, 32'hAAAA, 5'd9, 5'd2, 32'hAAAA, 32'h1234, 32'h1234};
    vt[6] = '{2'b11, 5'd9, 5'd10, 32'h5555, 32'h6666, 5'd9, 5'd10, 32'h5555, 32'h6666, 32'h1234};
    vt[7] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd9, 5'd3, 32'h5555, 32'h0, 32'h1234};

    foreach (m_mem[i]) m_mem[i] = 'x;
    reset       = 1'b0;
    b_clear_req = 1'b0;
    b_we        = 1'b0;
    b_wa        = 3'd0;
    b_wd        = 32'h0;
    b_ra        = 3'd0;
    b_mark_en   = 1'b0;
    b_mark_addr = 3'd0;
    idle();

    // Power-up reset and the first clear walk, with writes poked throughout.
    apply_reset("por");
    expect_clear_walk("por", 1'b1);

    // Vector table on DUT A.
    for (int i = 0; i < 8; i++) begin
      drive(vt[i].we, vt[i].wa0, vt[i].wa1, vt[i].wd0, vt[i].wd1, vt[i].ra0, vt[i].ra1);
      settle();
      check($sformatf("vec%0d_rd0", i), 64'(rd[31:0]), 64'(vt[i].e_rd0));
      check($sformatf("vec%0d_rd1", i), 64'(rd[63:32]), 64'(vt[i].e_rd1));
      check($sformatf("vec%0d_dbg", i), 64'(dbg_q), 64'(vt[i].e_dbg));
      $display("vec %0d: we=%b wa=%0d/%0d ra=%0d/%0d rd=%h/%h dbg=%h",
               i, we, vt[i].wa0, vt[i].wa1, vt[i].ra0, vt[i].ra1, rd[31:0], rd[63:32], dbg_q);
      edge_();
    end
    idle();

    // DUT B: no zero register, no bypass.
    b_we = 1'b1; b_wa = 3'd0; b_wd = 32'hDEADBEEF; b_ra = 3'd0;
    #2;
    check("b_ready", 64'(b_ready), 64'h1);
    check("b_rd0_prewrite_nobypass", 64'(b_rd), 64'h0);
    @(posedge clk); #1;
    b_wa = 3'd2; b_wd = 32'h77; b_ra = 3'd0;
    #2;
    check("b_rd0_deadbeef", 64'(b_rd), 64'hDEADBEEF);
    b_ra = 3'd2;
    #1;
    check("b_rd2_prewrite_nobypass", 64'(b_rd), 64'h0);
    @(posedge clk); #1;
    b_we = 1'b0;
    #2;
    check("b_rd2_after", 64'(b_rd), 64'h77);
    check("b_dbg_v0", 64'(b_dbg), 64'h77);
    $display("dut_b: rd(2)=%h dbg=%h", b_rd, b_dbg);

    // Run-time clear: reg 2 holds 0x1234 from the table.
    settle();
    check("pre_clear_dbg", 64'(dbg_q), 64'h1234);
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    expect_clear_walk("clr", 1'b0);
    settle();
    check("post_clear_dbg_zero", 64'(dbg_q), 64'h0);
    drive(2'b01, 5'd2, 5'd0, 32'h1234, 32'h0, 5'd2, 5'd0);
    step();
    idle();
    settle();
    check("dbg_after_write", 64'(dbg_q), 64'h1234);
    $display("clr: dbg_q=%h after rewrite", dbg_q);

    // Reset asserted mid-clear after 10 clear edges.
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    for (int i = 0; i < 10; i++) step();
    apply_reset("midclr");
    expect_clear_walk("midclr", 1'b0);

`ifdef MIPS_REGFILE_SCOREBOARD_EN
    // Scoreboard: mark, retire by write, mark+write in one cycle.
    idle();
    mark_en = 1'b1; mark_addr = 5'd7; ra = {5'd0, 5'd7};
    step();
    mark_en = 1'b0;
    settle();
    check("sb_mark7", 64'(rd_pending[0]), 64'h1);
    edge_();
    drive(2'b01, 5'd7, 5'd0, 32'h99, 32'h0, 5'd7, 5'd0);
    settle();
    check("sb_write7_bypass", 64'(rd_pending[0]), 64'h0);
    edge_();
    drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd7, 5'd0);
    settle();
    check("sb_write7_cleared", 64'(rd_pending[0]), 64'h0);
    edge_();
    drive(2'b01, 5'd7, 5'd0, 32'hAB, 32'h0, 5'd7, 5'd0);
    mark_en = 1'b1; mark_addr = 5'd7;
    step();
    idle();
    ra = {5'd0, 5'd7};
    settle();
    check("sb_mark_wins", 64'(rd_pending[0]), 64'h1);
    edge_();
    $display("scoreboard: pending(7)=%0b", rd_pending[0]);
`endif

    // Randomised traffic against the model; clear requests only on idle cycles.
    for (int i = 0; i < 600; i++) begin
      drive(2'($urandom), 5'($urandom_range(0, 11)), 5'($urandom_range(0, 11)),
            $urandom, $urandom,
            5'(($urandom_range(0, 7) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 11)),
            5'($urandom_range(0, 11)));
      mark_en   = ($urandom_range(0, 3) == 0);
      mark_addr = 5'($urandom_range(0, 11));
      clear_req = 1'b0;
      if ($urandom_range(0, 79) == 0) begin
        we        = 2'b00;
        clear_req = 1'b1;
      end
      step();
    end
    idle();
    $display("random: 600 cycles done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
